// File: rtl/comparator_2bit.sv
// Registered magnitude comparator: one-hot gt/eq/lt flags one cycle after a valid sample.
// SIGNED=1 treats the MSB as a two's-complement sign bit.
module comparator_2bit #(
    parameter int WIDTH  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_MASK =
        (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic             gt_next;
    logic             lt_next;
    logic             eq_next;
    logic             decided;

    assign a_cmp = A ^ SIGN_MASK;
    assign b_cmp = B ^ SIGN_MASK;

    // MSB-first cascade: the highest differing bit decides gt/lt.
    always_comb begin
        gt_next = 1'b0;
        lt_next = 1'b0;
        decided = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (a_cmp[i] != b_cmp[i])) begin
                gt_next = a_cmp[i];
                lt_next = b_cmp[i];
                decided = 1'b1;
            end
        end
        eq_next = ~decided;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            A_gt_B    <= 1'b0;
            A_eq_B    <= 1'b0;
            A_lt_B    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                A_gt_B <= gt_next;
                A_eq_B <= eq_next;
                A_lt_B <= lt_next;
            end
        end
    end

endmodule

// File: tb/tb_comparator_2bit.sv
// Self-checking bench for comparator_2bit: unsigned and signed instances share stimulus
// and are compared against an integer-arithmetic reference model.
module tb_comparator_2bit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] a_in = '0;
    logic [1:0] b_in = '0;

    logic       ov_u, gt_u, eq_u, lt_u;
    logic       ov_s, gt_s, eq_s, lt_s;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: held flags {gt,eq,lt} and expected out_valid
    logic [2:0] exp_u = '0;
    logic [2:0] exp_s = '0;
    logic       exp_ov = 1'b0;

    always #5 clk = ~clk;

    comparator_2bit #(.WIDTH(2), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_in), .B(b_in),
        .out_valid(ov_u), .A_gt_B(gt_u), .A_eq_B(eq_u), .A_lt_B(lt_u)
    );

    comparator_2bit #(.WIDTH(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(a_in), .B(b_in),
        .out_valid(ov_s), .A_gt_B(gt_s), .A_eq_B(eq_s), .A_lt_B(lt_s)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] rel(input int x, input int y);
        if (x > y)       return 3'b100;
        else if (x == y) return 3'b010;
        else             return 3'b001;
    endfunction

    function automatic int as_signed(input logic [1:0] v);
        int r;
        r = int'(v);
        if (r >= 2) r = r - 4;
        return r;
    endfunction

    // Apply one cycle of stimulus, advance the model, and check both instances.
    task automatic cycle(input logic r, input logic v, input logic [1:0] a, input logic [1:0] b);
        rst      = r;
        in_valid = v;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_ov = 1'b0;
            exp_u  = '0;
            exp_s  = '0;
        end else begin
            exp_ov = v;
            if (v) begin
                exp_u = rel(int'(a), int'(b));
                exp_s = rel(as_signed(a), as_signed(b));
            end
        end
        check("unsigned", {ov_u, gt_u, eq_u, lt_u}, {exp_ov, exp_u});
        check("signed",   {ov_s, gt_s, eq_s, lt_s}, {exp_ov, exp_s});
        if (exp_ov) begin
            check("onehot_u", 4'($countones({gt_u, eq_u, lt_u})), 4'd1);
            check("onehot_s", 4'($countones({gt_s, eq_s, lt_s})), 4'd1);
        end
    endtask

    initial begin
        // reset held for two cycles with a valid sample present, then one idle cycle
        cycle(1'b1, 1'b1, 2'd3, 2'd0);
        check("reset_zero", {ov_u, gt_u, eq_u, lt_u}, 4'b0000);
        cycle(1'b1, 1'b1, 2'd3, 2'd0);
        cycle(1'b0, 1'b0, 2'd3, 2'd0);
        check("post_reset_zero", {ov_u, gt_u, eq_u, lt_u}, 4'b0000);

        // exhaustive sweep, one pair per cycle
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                cycle(1'b0, 1'b1, 2'(a), 2'(b));
                if (a == 2 && b == 1) begin
                    check("spot_gt_u", {ov_u, gt_u, eq_u, lt_u}, 4'b1100);
                    check("spot_lt_s", {ov_s, gt_s, eq_s, lt_s}, 4'b1001);
                end
                if (a == 1 && b == 1) check("spot_eq_u", {ov_u, gt_u, eq_u, lt_u}, 4'b1010);
                if (a == 0 && b == 3) check("spot_lt_u", {ov_u, gt_u, eq_u, lt_u}, 4'b1001);
                if (a == 3 && b == 2) check("spot_gt_s", {ov_s, gt_s, eq_s, lt_s}, 4'b1100);
            end
        end

        // back-to-back
        cycle(1'b0, 1'b1, 2'd3, 2'd2);
        check("b2b_gt", {ov_u, gt_u, eq_u, lt_u}, 4'b1100);
        cycle(1'b0, 1'b1, 2'd2, 2'd3);
        check("b2b_lt", {ov_u, gt_u, eq_u, lt_u}, 4'b1001);
        cycle(1'b0, 1'b1, 2'd3, 2'd3);
        check("b2b_eq", {ov_u, gt_u, eq_u, lt_u}, 4'b1010);

        // idle hold: flags keep the last result while inputs change
        cycle(1'b0, 1'b1, 2'd1, 2'd2);
        cycle(1'b0, 1'b0, 2'd3, 2'd0);
        check("idle_hold", {ov_u, gt_u, eq_u, lt_u}, 4'b0001);
        cycle(1'b0, 1'b0, 2'd2, 2'd1);
        check("idle_hold2", {ov_u, gt_u, eq_u, lt_u}, 4'b0001);

        // reset mid-stream wins over a valid sample
        cycle(1'b0, 1'b1, 2'd2, 2'd2);
        cycle(1'b1, 1'b1, 2'd3, 2'd1);
        check("midstream_rst", {ov_u, gt_u, eq_u, lt_u}, 4'b0000);
        cycle(1'b0, 1'b1, 2'd3, 2'd1);
        check("after_rst", {ov_u, gt_u, eq_u, lt_u}, 4'b1100);

        // randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) == 0), 1'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
